p2s_shift_ctrl: RTL and testbench

Sequencer for the 64-bit load/shift datapath that feeds the board's serial display shift-register chain. On a start request it parallel-loads a word into an internal shift register (the mux select in load position), then switches the select to the shift path. It clocks the word out serially with a divided serial clock, clear and latch strobes, and signals completion with a busy/done handshake.

---
 rtl/p2s_shift_ctrl.sv | 161 ++++++++++++++++
 tb/tb_p2s_shift_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_shift_ctrl.sv
// p2s_shift_ctrl: load/shift sequencer for the serial display shift-register
// chain. Parallel-loads a word, then clocks it out with a divided serial clock,
// a clear strobe before the bits and a latch strobe after them.
// Optional build macro: P2S_LSB_FIRST_EN (shift out LSB first instead of MSB).
module p2s_shift_ctrl #(
  parameter int DATA_W  = 64,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              sel_load,
  output logic              busy,
  output logic              done,
  output logic              s_clk,
  output logic              s_dat,
  output logic              s_clr,
  output logic              s_en
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    SH_LO,
    SH_HI,
    LATCH,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt, shreg_shift;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
  logic                out_bit;
  logic                sel_load_nxt, busy_nxt, done_nxt;
  logic                s_clk_nxt, s_dat_nxt, s_clr_nxt, s_en_nxt;

  // Shift direction and the bit presented on s_dat (taken from the next
  // shreg value so the registered s_dat lines up with the new bit).
  always_comb begin
`ifdef P2S_LSB_FIRST_EN
    shreg_shift = {1'b0, shreg[DATA_W-1:1]};
    out_bit     = shreg_nxt[0];
`else
    shreg_shift = {shreg[DATA_W-2:0], 1'b0};
    out_bit     = shreg_nxt[DATA_W-1];
`endif
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      sel_load <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s_clk    <= 1'b0;
      s_dat    <= 1'b0;
      s_clr    <= 1'b1;
      s_en     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      div_cnt  <= div_cnt_nxt;
      sel_load <= sel_load_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      s_clk    <= s_clk_nxt;
      s_dat    <= s_dat_nxt;
      s_clr    <= s_clr_nxt;
      s_en     <= s_en_nxt;
    end
  end

  // Next-state, shift-register and counter logic.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        shreg_nxt   = par_data;
        bit_cnt_nxt = '0;
        div_cnt_nxt = '0;
        state_nxt   = CLR;
      end
      CLR: state_nxt = SH_LO;
      SH_LO: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          state_nxt   = SH_HI;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      SH_HI: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          shreg_nxt   = shreg_shift;
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          state_nxt   = (bit_cnt == BIT_LAST) ? LATCH : SH_LO;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      LATCH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values decoded from the upcoming state so every output is a flop.
  always_comb begin
    sel_load_nxt = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    s_clk_nxt    = 1'b0;
    s_dat_nxt    = 1'b0;
    s_clr_nxt    = 1'b1;
    s_en_nxt     = 1'b0;
    unique case (state_nxt)
      LOAD: begin
        sel_load_nxt = 1'b1;
        busy_nxt     = 1'b1;
      end
      CLR: begin
        busy_nxt  = 1'b1;
        s_clr_nxt = 1'b0;
      end
      SH_LO: begin
        busy_nxt  = 1'b1;
        s_dat_nxt = out_bit;
      end
      SH_HI: begin
        busy_nxt  = 1'b1;
        s_clk_nxt = 1'b1;
        s_dat_nxt = out_bit;
      end
      LATCH: begin
        busy_nxt = 1'b1;
        s_en_nxt = 1'b1;
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_p2s_shift_ctrl.sv
// Testbench for p2s_shift_ctrl: behavioural timeline model plus directed and
// randomized transfers.
module tb_p2s_shift_ctrl;

  localparam int DW    = 64;
  localparam int CD    = 2;
  localparam int TOTAL = 2 * CD * DW + 4;  // cycles from LOAD to DONE inclusive

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] par_data;
  logic          sel_load, busy, done, s_clk, s_dat, s_clr, s_en;

  p2s_shift_ctrl #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .par_data (par_data),
    .sel_load (sel_load),
    .busy     (busy),
    .done     (done),
    .s_clk    (s_clk),
    .s_dat    (s_dat),
    .s_clr    (s_clr),
    .s_en     (s_en)
  );

  always #5 if (clk_run) clk = ~clk;

  typedef struct packed {
    logic sel, bsy, dn, sclk, sdat, sclr, sen;
  } outs_t;

  int            checks = 0;
  int            failures = 0;
  int            mk = 0;          // model: 0 = idle, k = k-th cycle of a transfer
  logic [DW-1:0] mword = '0;      // model: word captured at the end of LOAD
  int            done_cnt = 0;
  int            en_cnt = 0;
  logic [DW-1:0] last_stream = '0;
  bit            rise_q[$];

  // Position inside the word of the i-th bit sent on the serial line.
  function automatic int bit_pos(input int i);
`ifdef P2S_LSB_FIRST_EN
    return i;
`else
    return DW - 1 - i;
`endif
  endfunction

  // Outputs required during the k-th cycle of a transfer (k=0: idle/reset).
  function automatic outs_t expect_at(input int k, input logic [DW-1:0] w);
    outs_t o;
    int    j;
    o = '{sel:1'b0, bsy:1'b0, dn:1'b0, sclk:1'b0, sdat:1'b0, sclr:1'b1, sen:1'b0};
    if (k == 1) begin
      o.sel = 1'b1; o.bsy = 1'b1;
    end else if (k == 2) begin
      o.bsy = 1'b1; o.sclr = 1'b0;
    end else if (k >= 3 && k <= TOTAL - 2) begin
      j      = k - 3;
      o.bsy  = 1'b1;
      o.sclk = (j % (2 * CD)) >= CD;
      o.sdat = w[bit_pos(j / (2 * CD))];
    end else if (k == TOTAL - 1) begin
      o.bsy = 1'b1; o.sen = 1'b1;
    end else if (k == TOTAL) begin
      o.dn = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic pulse_start(input logic [DW-1:0] w);
    par_data = w;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  initial begin
    int  sel_cnt, sel_cyc, clr_cnt, clr_cyc, en_cyc, dn_cyc, dn_n, base_dn, base_en;
    int  loads[$];
    int  dns[$];
    logic busy_at_done;
    bit   found;

    rst = 1'b0; start = 1'b0; par_data = '0;

    fork
      // Reference model: advances one transfer cycle per clock.
      forever begin
        @(posedge clk or posedge rst);
        if (rst) mk = 0;
        else if (mk == 0) begin
          if (start) mk = 1;
        end else begin
          if (mk == 1) mword = par_data;
          mk = (mk == TOTAL) ? 0 : mk + 1;
        end
      end
      // Per-cycle compare plus serial-stream scoreboard.
      begin
        logic  prev_sclk;
        outs_t exp_o, act_o;
        logic [DW-1:0] gotw;
        prev_sclk = 1'b0;
        forever begin
          @(negedge clk);
          exp_o = expect_at(mk, mword);
          act_o = '{sel:sel_load, bsy:busy, dn:done, sclk:s_clk, sdat:s_dat, sclr:s_clr, sen:s_en};
          checks++;
          if (act_o !== exp_o) begin
            failures++;
            $display("FAIL cycle_outputs(sel,busy,done,sclk,sdat,sclr,sen) actual=%b required=%b t=%0t",
                     act_o, exp_o, $time);
          end
          if (rst || sel_load) rise_q.delete();
          else if (s_clk && !prev_sclk) rise_q.push_back(s_dat);
          prev_sclk = s_clk;
          if (s_en) en_cnt++;
          if (done && !rst) begin
            done_cnt++;
            gotw = '0;
            foreach (rise_q[i]) if (i < DW) gotw[bit_pos(i)] = rise_q[i];
            checks++;
            if (rise_q.size() != DW || gotw !== mword) begin
              failures++;
              $display("FAIL serial_stream actual=%0h (%0d rises) required=%0h (%0d rises)",
                       gotw, rise_q.size(), mword, DW);
            end
            last_stream = gotw;
            rise_q.delete();
          end
        end
      end
    join_none

    // 1. Reset with no clock running.
    #1 rst = 1'b1;
    #3;
    chk("rst_sel_load", DW'(sel_load), '0);
    chk("rst_busy",     DW'(busy),     '0);
    chk("rst_done",     DW'(done),     '0);
    chk("rst_s_clk",    DW'(s_clk),    '0);
    chk("rst_s_dat",    DW'(s_dat),    '0);
    chk("rst_s_clr",    DW'(s_clr),    DW'(1));
    chk("rst_s_en",     DW'(s_en),     '0);
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_busy", DW'(busy), '0);
      chk("idle_s_clk", DW'(s_clk), '0);
    end

    // 2. Single transfer, literal timing.
    sel_cnt = 0; sel_cyc = 0; clr_cnt = 0; clr_cyc = 0; en_cyc = 0; dn_cyc = 0;
    busy_at_done = 1'b1;
    pulse_start(64'h8000_0000_0000_0001);
    for (int c = 1; c <= TOTAL + 2; c++) begin
      if (sel_load) begin sel_cnt++; sel_cyc = c; end
      if (!s_clr) begin clr_cnt++; clr_cyc = c; end
      if (s_en) en_cyc = c;
      if (done) begin dn_cyc = c; busy_at_done = busy; end
      @(negedge clk);
    end
    chk("t2_sel_load_cycles", DW'(sel_cnt), DW'(1));
    chk("t2_sel_load_cycle",  DW'(sel_cyc), DW'(1));
    chk("t2_s_clr_cycles",    DW'(clr_cnt), DW'(1));
    chk("t2_s_clr_cycle",     DW'(clr_cyc), DW'(2));
    chk("t2_s_en_cycle",      DW'(en_cyc),  DW'(259));
    chk("t2_done_cycle",      DW'(dn_cyc),  DW'(260));
    chk("t2_busy_at_done",    DW'(busy_at_done), '0);
    chk("t2_stream",          last_stream, 64'h8000_0000_0000_0001);

    // 3. par_data change after LOAD and ignored start pulses.
    dn_n = 0;
    pulse_start(64'hA5A5_A5A5_A5A5_A5A5);
    for (int c = 1; c <= 300; c++) begin
      if (c == 2) par_data = 64'hFFFF_FFFF_FFFF_FFFF;
      start = (c == 50 || c == 100);
      if (done) dn_n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("t3_done_pulses", DW'(dn_n), DW'(1));
    chk("t3_stream", last_stream, 64'hA5A5_A5A5_A5A5_A5A5);

    // 4. Back-to-back with start held high.
    repeat (3) @(negedge clk);
    par_data = {$urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 540; c++) begin
      if (sel_load) loads.push_back(c);
      if (done) dns.push_back(c);
      if (c == 270) start = 1'b0;
      @(negedge clk);
    end
    chk("t4_loads", DW'(loads.size()), DW'(2));
    chk("t4_dones", DW'(dns.size()), DW'(2));
    if (loads.size() == 2 && dns.size() == 2) begin
      chk("t4_load2_cycle", DW'(loads[1]), DW'(262));
      chk("t4_done1_cycle", DW'(dns[0]), DW'(260));
      chk("t4_done2_cycle", DW'(dns[1]), DW'(521));
    end

    // 5. Asynchronous reset mid-transfer.
    pulse_start({$urandom, $urandom});
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (rise_q.size() >= 30) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL t5_wait_30_rises actual=timeout required=30 rises");
    end
    #2 rst = 1'b1;
    #1;
    chk("t5_s_clk_now", DW'(s_clk), '0);
    chk("t5_s_dat_now", DW'(s_dat), '0);
    chk("t5_busy_now",  DW'(busy),  '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    base_dn = done_cnt; base_en = en_cnt;
    repeat (50) @(negedge clk);
    chk("t5_no_done_after_abort", DW'(done_cnt), DW'(base_dn));
    chk("t5_no_s_en_after_abort", DW'(en_cnt), DW'(base_en));
    pulse_start(64'h1);
    repeat (TOTAL + 2) @(negedge clk);
    chk("t5_fresh_done", DW'(done_cnt), DW'(base_dn + 1));
    chk("t5_fresh_stream", last_stream, 64'h1);

    // Randomized traffic: random words every cycle, sparse start requests.
    for (int c = 0; c < 4000; c++) begin
      par_data = {$urandom, $urandom};
      start    = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (TOTAL + 5) @(negedge clk);
    chk("rand_transfers_seen", DW'(done_cnt > base_dn + 5), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
